// File: rtl/cpu_pkg.sv
// Shared definitions for the control-step sequencer.
//   state_t        : sequencer states (IDLE, fetch T0-T2, execute T3-T6, ALU wait T4W)
//   OP_*           : opcode constants; opcodes above OP_MAX_LEGAL are unsupported
//   IR_*_LO/HI     : instruction-register field positions
//   is_multicycle  : true for opcodes whose result arrives over several cycles (MUL/DIV)
package cpu_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T4W  = 4'd6,
        T5   = 4'd7,
        T6   = 4'd8
    } state_t;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_MUL       = 5'b00011;
    localparam logic [OPC_W-1:0] OP_DIV       = 5'b00100;
    localparam logic [OPC_W-1:0] OP_MAX_LEGAL = 5'b01111;

    localparam int IR_OPC_HI = 31;
    localparam int IR_OPC_LO = 27;
    localparam int IR_RA_HI  = 26;
    localparam int IR_RA_LO  = 23;
    localparam int IR_RB_HI  = 22;
    localparam int IR_RB_LO  = 19;
    localparam int IR_RC_HI  = 18;
    localparam int IR_RC_LO  = 15;

    function automatic logic is_multicycle(input logic [OPC_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Register-select to one-hot decoder with enable.
//   en     in   decode enable; all outputs 0 when low
//   sel    in   REG_SEL_W register index
//   onehot out  NUM_REGS one-hot vector; the bit is suppressed when sel >= NUM_REGS
//   oor    out  high when enabled and sel addresses a register that does not exist
module onehot_dec #(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4
) (
    input  logic                 en,
    input  logic [REG_SEL_W-1:0] sel,
    output logic [NUM_REGS-1:0]  onehot,
    output logic                 oor
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (sel == REG_SEL_W'(i));
        end
        oor = en && (int'(sel) >= NUM_REGS);
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Control-step sequencer driving the datapath strobes for instruction fetch
// (T0-T2) and three-operand ALU execute (T3-T6), as a clocked Moore machine
// with a memory-ready wait in T1, a variable-latency ALU wait (T4W) for
// MUL/DIV, and a run mode that chains instructions without passing IDLE.
//
// Ports:
//   clk, clr            clock (rising edge), asynchronous active-low reset
//   start, run          begin from IDLE / continue after end-of-instruction
//   ir_q                IR contents (opcode, ra, rb, rc fields)
//   mem_rdy, alu_done   wait-state releases, only looked at in T1 / T4W
//   reg_in, reg_out     one-hot register load / drive
//   pc_out .. hi_in     single-bit datapath strobes
//   alu_op              opcode presented to the ALU in T4/T4W, else 0
//   busy, done, illegal status; done and illegal are single-cycle pulses
//   state_dbg           current state, for observation only
//
// Handshake: mem_rdy and alu_done are level "result valid" indications from
// the datapath; the sequencer advances on the first cycle it sees them high
// while in the matching wait state and ignores them in every other state.
module ctrl_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4,
    parameter int OPCODE_W  = 5,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                run,
    input  logic [DATA_W-1:0]   ir_q,
    input  logic                mem_rdy,
    input  logic                alu_done,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic                pc_out,
    output logic                pc_in,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                read,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlow_out,
    output logic                zhigh_out,
    output logic                lo_in,
    output logic                hi_in,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output state_t              state_dbg
);

    state_t state_q, state_d;

    // High once the current T1 visit has lasted a cycle; PC reload happens
    // only on the first T1 cycle so a memory wait cannot re-increment it.
    logic t1_seen_q;

    logic [OPCODE_W-1:0]  opc_q, opc;
    logic [REG_SEL_W-1:0] ra_q, rb_q, rc_q, ra, rb, rc;

    logic opc_ok, multi, illegal_op;
    logic out_en, in_en, out_oor, in_oor;
    logic [REG_SEL_W-1:0] out_sel;

    // Low IR bits carry no control information.
    logic unused_ir;
    assign unused_ir = ^ir_q[IR_RC_LO-1:0];

    // The IR loads on the same edge that enters T3, so during T3 the fields
    // come straight from ir_q; they are held from the end of T3 onward.
    always_comb begin
        if (state_q == T3) begin
            opc = ir_q[IR_OPC_LO +: OPCODE_W];
            ra  = ir_q[IR_RA_LO  +: REG_SEL_W];
            rb  = ir_q[IR_RB_LO  +: REG_SEL_W];
            rc  = ir_q[IR_RC_LO  +: REG_SEL_W];
        end else begin
            opc = opc_q;
            ra  = ra_q;
            rb  = rb_q;
            rc  = rc_q;
        end
    end

    assign opc_ok = (opc <= OPCODE_W'(OP_MAX_LEGAL));
    assign multi  = is_multicycle(OPC_W'(opc));

    // reg_out is driven only in T3 (rb) and T4 (rc); reg_in only in T5 of a
    // single-cycle op. These never overlap, so the two vectors are exclusive.
    assign out_en  = (state_q == T3) || (state_q == T4);
    assign out_sel = (state_q == T4) ? rc : rb;
    assign in_en   = (state_q == T5) && !multi;

    onehot_dec #(
        .NUM_REGS  (NUM_REGS),
        .REG_SEL_W (REG_SEL_W)
    ) u_out_dec (
        .en     (out_en),
        .sel    (out_sel),
        .onehot (reg_out),
        .oor    (out_oor)
    );

    onehot_dec #(
        .NUM_REGS  (NUM_REGS),
        .REG_SEL_W (REG_SEL_W)
    ) u_in_dec (
        .en     (in_en),
        .sel    (ra),
        .onehot (reg_in),
        .oor    (in_oor)
    );

    assign illegal   = illegal_op || out_oor || in_oor;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            t1_seen_q <= 1'b0;
            opc_q     <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
        end else begin
            t1_seen_q <= (state_q == T1);
            if (state_q == T3) begin
                opc_q <= opc;
                ra_q  <= ra;
                rb_q  <= rb;
                rc_q  <= rc;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_out     = 1'b0;
        pc_in      = 1'b0;
        inc_pc     = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        read       = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        zlow_out   = 1'b0;
        zhigh_out  = 1'b0;
        lo_in      = 1'b0;
        hi_in      = 1'b0;
        alu_op     = '0;
        done       = 1'b0;
        illegal_op = 1'b0;
        busy       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) state_d = T0;
            end
            T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
                state_d = T1;
            end
            T1: begin
                zlow_out = 1'b1;
                pc_in    = !t1_seen_q;
                read     = 1'b1;
                mdr_in   = 1'b1;
                if (mem_rdy) state_d = T2;
            end
            T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = T3;
            end
            T3: begin
                y_in = 1'b1;
                if (!opc_ok) begin
                    illegal_op = 1'b1;
                    done       = 1'b1;
                    state_d    = run ? T0 : IDLE;
                end else begin
                    state_d = T4;
                end
            end
            T4: begin
                alu_op  = opc;
                z_in    = 1'b1;
                state_d = multi ? T4W : T5;
            end
            T4W: begin
                alu_op = opc;
                z_in   = 1'b1;
                if (alu_done) state_d = T5;
            end
            T5: begin
                zlow_out = 1'b1;
                if (multi) begin
                    lo_in   = 1'b1;
                    state_d = T6;
                end else begin
                    done    = 1'b1;
                    state_d = run ? T0 : IDLE;
                end
            end
            T6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                done      = 1'b1;
                state_d   = run ? T0 : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer. Two instances share every input:
// the default 16-register build and an 8-register build used to observe
// out-of-range register suppression. Each vector row gives the inputs held
// for one clock and the outputs expected right after that clock edge.
module tb_ctrl_sequencer;
    import cpu_pkg::*;

    localparam logic [4:0] OPC_ADD = 5'b00101;
    localparam logic [4:0] OPC_MULT = 5'b00011;
    localparam logic [4:0] OPC_DIVD = 5'b00100;
    localparam logic [4:0] OPC_BAD = 5'b11111;

    // Strobe bit positions in {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
    // read, ir_in, y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in}.
    localparam logic [13:0] S_PC_OUT  = 14'h2000;
    localparam logic [13:0] S_PC_IN   = 14'h1000;
    localparam logic [13:0] S_INC_PC  = 14'h0800;
    localparam logic [13:0] S_MAR_IN  = 14'h0400;
    localparam logic [13:0] S_MDR_IN  = 14'h0200;
    localparam logic [13:0] S_MDR_OUT = 14'h0100;
    localparam logic [13:0] S_READ    = 14'h0080;
    localparam logic [13:0] S_IR_IN   = 14'h0040;
    localparam logic [13:0] S_Y_IN    = 14'h0020;
    localparam logic [13:0] S_Z_IN    = 14'h0010;
    localparam logic [13:0] S_ZLOW    = 14'h0008;
    localparam logic [13:0] S_ZHIGH   = 14'h0004;
    localparam logic [13:0] S_LO_IN   = 14'h0002;
    localparam logic [13:0] S_HI_IN   = 14'h0001;

    // Expected phase after the edge; T1F is the first T1 cycle, T1W a
    // memory-wait repeat, T5M the T5 of a MUL/DIV.
    typedef enum int {P_IDLE, P_T0, P_T1F, P_T1W, P_T2, P_T3, P_T4, P_T4W,
                      P_T5, P_T5M, P_T6} phase_t;

    typedef struct {
        logic        clr, start, run, mem_rdy, alu_done;
        logic [4:0]  opc;
        logic [3:0]  ra, rb, rc;
        phase_t      ph;
        logic [15:0] rout, rin;
        logic        dn, il, il8;
    } vec_t;

    typedef struct packed {
        logic [13:0] stb;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  aop;
        logic        dn;
        logic        il;
        logic        busy;
        logic [7:0]  rout8;
        logic        il8;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 1'b0, start = 1'b0, run = 1'b0, mem_rdy = 1'b0, alu_done = 1'b0;
    logic [31:0] ir_q = '0;

    logic [15:0] reg_in, reg_out;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in, busy, done, illegal;
    logic [4:0] alu_op;
    state_t state_dbg;

    logic [7:0] reg_in8, reg_out8;
    logic pc_out8, pc_in8, inc_pc8, mar_in8, mdr_in8, mdr_out8, read8, ir_in8;
    logic y_in8, z_in8, zlow_out8, zhigh_out8, lo_in8, hi_in8, busy8, done8, illegal8;
    logic [4:0] alu_op8;
    state_t state_dbg8;

    ctrl_sequencer u_dut (
        .clk(clk), .clr(clr), .start(start), .run(run), .ir_q(ir_q),
        .mem_rdy(mem_rdy), .alu_done(alu_done),
        .reg_in(reg_in), .reg_out(reg_out),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
        .lo_in(lo_in), .hi_in(hi_in), .alu_op(alu_op), .busy(busy),
        .done(done), .illegal(illegal), .state_dbg(state_dbg)
    );

    ctrl_sequencer #(.NUM_REGS(8)) u_dut8 (
        .clk(clk), .clr(clr), .start(start), .run(run), .ir_q(ir_q),
        .mem_rdy(mem_rdy), .alu_done(alu_done),
        .reg_in(reg_in8), .reg_out(reg_out8),
        .pc_out(pc_out8), .pc_in(pc_in8), .inc_pc(inc_pc8), .mar_in(mar_in8),
        .mdr_in(mdr_in8), .mdr_out(mdr_out8), .read(read8), .ir_in(ir_in8),
        .y_in(y_in8), .z_in(z_in8), .zlow_out(zlow_out8), .zhigh_out(zhigh_out8),
        .lo_in(lo_in8), .hi_in(hi_in8), .alu_op(alu_op8), .busy(busy8),
        .done(done8), .illegal(illegal8), .state_dbg(state_dbg8)
    );

    logic [13:0] stb_act;
    assign stb_act = {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read,
                      ir_in, y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in};

    // ---------------- scoreboard ----------------
    logic [62:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int row_n  = 0;

    function automatic logic [13:0] stb_of(input phase_t p);
        case (p)
            P_T0:    return S_PC_OUT | S_MAR_IN | S_INC_PC | S_Z_IN;
            P_T1F:   return S_ZLOW | S_PC_IN | S_READ | S_MDR_IN;
            P_T1W:   return S_ZLOW | S_READ | S_MDR_IN;
            P_T2:    return S_MDR_OUT | S_IR_IN;
            P_T3:    return S_Y_IN;
            P_T4:    return S_Z_IN;
            P_T4W:   return S_Z_IN;
            P_T5:    return S_ZLOW;
            P_T5M:   return S_ZLOW | S_LO_IN;
            P_T6:    return S_ZHIGH | S_HI_IN;
            default: return 14'h0000;
        endcase
    endfunction

    function automatic vec_t v(input int c, s, r, mr, ad, op, a, b, cc,
                               input phase_t ph, input int ro, ri, dn, il, il8);
        vec_t t;
        t.clr = (c != 0);   t.start = (s != 0);   t.run = (r != 0);
        t.mem_rdy = (mr != 0); t.alu_done = (ad != 0);
        t.opc = 5'(op); t.ra = 4'(a); t.rb = 4'(b); t.rc = 4'(cc);
        t.ph = ph; t.rout = 16'(ro); t.rin = 16'(ri);
        t.dn = (dn != 0); t.il = (il != 0); t.il8 = (il8 != 0);
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one row, push its expectation, clock, then pop and compare.
    task automatic cyc(input vec_t t);
        exp_t e;
        clr      = t.clr;
        start    = t.start;
        run      = t.run;
        mem_rdy  = t.mem_rdy;
        alu_done = t.alu_done;
        ir_q     = {t.opc, t.ra, t.rb, t.rc, 15'd0};
        e.stb   = stb_of(t.ph);
        e.rout  = t.rout;
        e.rin   = t.rin;
        e.aop   = (t.ph == P_T4 || t.ph == P_T4W) ? t.opc : 5'd0;
        e.dn    = t.dn;
        e.il    = t.il;
        e.busy  = (t.ph != P_IDLE);
        e.rout8 = t.rout[7:0];
        e.il8   = t.il8;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("strobes",  row_n, 16'(stb_act),  16'(e.stb));
        chk("reg_out",  row_n, reg_out,       e.rout);
        chk("reg_in",   row_n, reg_in,        e.rin);
        chk("alu_op",   row_n, 16'(alu_op),   16'(e.aop));
        chk("done",     row_n, 16'(done),     16'(e.dn));
        chk("illegal",  row_n, 16'(illegal),  16'(e.il));
        chk("busy",     row_n, 16'(busy),     16'(e.busy));
        chk("reg_out8", row_n, 16'(reg_out8), 16'(e.rout8));
        chk("illegal8", row_n, 16'(illegal8), 16'(e.il8));
        row_n++;
    endtask

    vec_t tbl[$];

    initial begin
        // Reset state: held in reset, start is ignored.
        cyc(v(0, 1, 0, 1, 1, OPC_ADD, 1, 2, 3, P_IDLE, 0, 0, 0, 0, 0));
        cyc(v(0, 1, 0, 1, 1, OPC_ADD, 1, 2, 3, P_IDLE, 0, 0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_ADD, 1, 2, 3, P_IDLE, 0, 0, 0, 0, 0));

        // ADD ra=1 rb=2 rc=3, mem_rdy tied high; start held while busy and
        // alu_done high outside T4W, both ignored.
        tbl.push_back(v(1, 1, 0, 1, 1, OPC_ADD, 1, 2, 3, P_T0,   0,      0,      0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 1, OPC_ADD, 1, 2, 3, P_T1F,  0,      0,      0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 1, OPC_ADD, 1, 2, 3, P_T2,   0,      0,      0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 1, OPC_ADD, 1, 2, 3, P_T3,   'h0004, 0,      0, 0, 0));
        tbl.push_back(v(1, 1, 0, 1, 1, OPC_ADD, 1, 2, 3, P_T4,   'h0008, 0,      0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 1, OPC_ADD, 1, 2, 3, P_T5,   0,      'h0002, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 1, OPC_ADD, 1, 2, 3, P_IDLE, 0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 1, OPC_ADD, 1, 2, 3, P_IDLE, 0,      0,      0, 0, 0));
        // Unsupported opcode: illegal+done in T3, straight back to IDLE.
        tbl.push_back(v(1, 1, 0, 1, 0, OPC_BAD, 1, 2, 3, P_T0,   0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, OPC_BAD, 1, 2, 3, P_T1F,  0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, OPC_BAD, 1, 2, 3, P_T2,   0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, OPC_BAD, 1, 2, 3, P_T3,   'h0004, 0,      1, 1, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, OPC_BAD, 1, 2, 3, P_IDLE, 0,      0,      0, 0, 0));
        // run=1, two ADDs with rc=15: no bubble between them; the 8-register
        // build suppresses reg_out and flags illegal in T4.
        tbl.push_back(v(1, 1, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T0,   0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T1F,  0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T2,   0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T3,   'h0004, 0,      0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T4,   'h8000, 0,      0, 0, 1));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T5,   0,      'h0002, 1, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T0,   0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T1F,  0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T2,   0,      0,      0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T3,   'h0004, 0,      0, 0, 0));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T4,   'h8000, 0,      0, 0, 1));
        tbl.push_back(v(1, 0, 1, 1, 0, OPC_ADD, 1, 2, 15, P_T5,   0,      'h0002, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, OPC_ADD, 1, 2, 15, P_IDLE, 0,      0,      0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

        // mem_rdy low for the first two T1 cycles: read/mdr_in for three
        // cycles, pc_in only on the first, then T2 loads the IR.
        cyc(v(1, 1, 0, 0, 0, OPC_ADD, 1, 2, 3, P_T0,   0,      0,      0, 0, 0));
        cyc(v(1, 0, 0, 0, 0, OPC_ADD, 1, 2, 3, P_T1F,  0,      0,      0, 0, 0));
        cyc(v(1, 0, 0, 0, 0, OPC_ADD, 1, 2, 3, P_T1W,  0,      0,      0, 0, 0));
        cyc(v(1, 0, 0, 0, 0, OPC_ADD, 1, 2, 3, P_T1W,  0,      0,      0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_ADD, 1, 2, 3, P_T2,   0,      0,      0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_ADD, 1, 2, 3, P_T3,   'h0004, 0,      0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_ADD, 1, 2, 3, P_T4,   'h0008, 0,      0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_ADD, 1, 2, 3, P_T5,   0,      'h0002, 1, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_ADD, 1, 2, 3, P_IDLE, 0,      0,      0, 0, 0));

        // DIV ra=0: three T4W cycles, lo_in in T5, hi_in+done in T6, ten
        // cycles in total, no register load.
        cyc(v(1, 1, 0, 1, 0, OPC_DIVD, 0, 2, 3, P_T0,   0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_DIVD, 0, 2, 3, P_T1F,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_DIVD, 0, 2, 3, P_T2,   0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_DIVD, 0, 2, 3, P_T3,   'h0004, 0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_DIVD, 0, 2, 3, P_T4,   'h0008, 0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_DIVD, 0, 2, 3, P_T4W,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_DIVD, 0, 2, 3, P_T4W,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_DIVD, 0, 2, 3, P_T4W,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_DIVD, 0, 2, 3, P_T5M,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_DIVD, 0, 2, 3, P_T6,   0,      0, 1, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_DIVD, 0, 2, 3, P_IDLE, 0,      0, 0, 0, 0));

        // MUL aborted by a one-cycle reset in T4W; stays idle with stray
        // mem_rdy/alu_done until start, then runs a minimum-length MUL.
        cyc(v(1, 1, 0, 1, 0, OPC_MULT, 1, 2, 3, P_T0,   0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_T1F,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_T2,   0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_T3,   'h0004, 0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_T4,   'h0008, 0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_T4W,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_T4W,  0,      0, 0, 0, 0));
        cyc(v(0, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_IDLE, 0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_MULT, 1, 2, 3, P_IDLE, 0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_MULT, 1, 2, 3, P_IDLE, 0,      0, 0, 0, 0));
        cyc(v(1, 1, 0, 1, 1, OPC_MULT, 1, 2, 3, P_T0,   0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_MULT, 1, 2, 3, P_T1F,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_MULT, 1, 2, 3, P_T2,   0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_MULT, 1, 2, 3, P_T3,   'h0004, 0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_MULT, 1, 2, 3, P_T4,   'h0008, 0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_MULT, 1, 2, 3, P_T4W,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 1, OPC_MULT, 1, 2, 3, P_T5M,  0,      0, 0, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_T6,   0,      0, 1, 0, 0));
        cyc(v(1, 0, 0, 1, 0, OPC_MULT, 1, 2, 3, P_IDLE, 0,      0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
